mitch_log_div_pipe: RTL and testbench

//  Pipelined signed 16-bit approximate divider, Mitchell logarithmic method. Log-encodes |dividend|
//  and |divisor|, subtracts the logs, antilogs the difference into an unsigned Q16.16 magnitude

---
 rtl/mitch_log_div_pipe.sv | 136 +++++++++++++
 tb/tb_mitch_log_div_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mitch_log_div_pipe.sv
// Pipelined signed 16-bit Mitchell logarithmic divider, Q16.16 magnitude + sign, 3-cycle latency.
// Optional bias term enabled by defining MITCH_DIV_BIAS_EN.
module mitch_log_div_pipe #(
  parameter int unsigned FRAC_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quo_mag,
  output logic        quo_neg,
  output logic        div_by_zero
);

  localparam int unsigned LXW = 4 + FRAC_W;
  localparam int unsigned LW  = 6 + FRAC_W;

  // Log encoding {leading-one index, FRAC_W truncated bits below it}
  function automatic logic [LXW-1:0] log_enc(input logic [15:0] m);
    logic [3:0]  k;
    logic [15:0] norm;
    k = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) k = 4'(i);
    end
    norm = m << (4'd15 - k);
    return {k, norm[14 -: FRAC_W]};
  endfunction

  logic           s1_v_q, s2_v_q, s3_v_q;
  logic           s1_en, s2_en, s3_en;
  logic [LXW-1:0] s1_lx_q, s1_ly_q, s1_lx_d, s1_ly_d;
  logic           s1_neg_q, s1_dz_q, s1_zero_q, s1_neg_d, s1_dz_d, s1_zero_d;
  logic [LW-1:0]  s2_l_q, s2_l_d;
  logic           s2_neg_q, s2_dz_q, s2_zero_q;
  logic [31:0]    quo_mag_q, quo_mag_d;
  logic           quo_neg_q, div_by_zero_q;
  logic [15:0]    mag_a, mag_b;
  logic [4:0]     sh;

  // Stall chain: a stage loads when empty or when its contents move on
  always_comb begin
    s3_en = ~s3_v_q | out_ready;
    s2_en = ~s2_v_q | s3_en;
    s1_en = ~s1_v_q | s2_en;
  end

  // Stage 1: abs, leading-one detect, normalise, zero flags, sign
  always_comb begin
    mag_a     = dividend[15] ? 16'(-dividend) : dividend;
    mag_b     = divisor[15]  ? 16'(-divisor)  : divisor;
    s1_lx_d   = log_enc(mag_a);
    s1_ly_d   = log_enc(mag_b);
    s1_dz_d   = (divisor == 16'd0);
    s1_zero_d = (dividend == 16'd0);
    s1_neg_d  = dividend[15] ^ divisor[15];
    if (s1_dz_d)        s1_neg_d = dividend[15];
    else if (s1_zero_d) s1_neg_d = 1'b0;
  end

  // Stage 2: log subtraction
  always_comb begin
`ifdef MITCH_DIV_BIAS_EN
    s2_l_d = LW'(s1_lx_q) - LW'(s1_ly_q) + LW'(2);
`else
    s2_l_d = LW'(s1_lx_q) - LW'(s1_ly_q);
`endif
  end

  // Stage 3: antilog; integer part (-15..15) offset by 15 to a non-negative shift
  always_comb begin
    sh        = 5'(s2_l_q[LW-1:FRAC_W] + 6'd15);
    quo_mag_d = 32'((48'({1'b1, s2_l_q[FRAC_W-1:0]}) << sh) >> (FRAC_W - 1));
    if (s2_dz_q)        quo_mag_d = 32'hFFFF_FFFF;
    else if (s2_zero_q) quo_mag_d = 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q        <= 1'b0;
      s2_v_q        <= 1'b0;
      s3_v_q        <= 1'b0;
      s1_lx_q       <= '0;
      s1_ly_q       <= '0;
      s1_neg_q      <= 1'b0;
      s1_dz_q       <= 1'b0;
      s1_zero_q     <= 1'b0;
      s2_l_q        <= '0;
      s2_neg_q      <= 1'b0;
      s2_dz_q       <= 1'b0;
      s2_zero_q     <= 1'b0;
      quo_mag_q     <= 32'd0;
      quo_neg_q     <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          s1_lx_q   <= s1_lx_d;
          s1_ly_q   <= s1_ly_d;
          s1_neg_q  <= s1_neg_d;
          s1_dz_q   <= s1_dz_d;
          s1_zero_q <= s1_zero_d;
        end
      end
      if (s2_en) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_l_q    <= s2_l_d;
          s2_neg_q  <= s1_neg_q;
          s2_dz_q   <= s1_dz_q;
          s2_zero_q <= s1_zero_q;
        end
      end
      if (s3_en) begin
        s3_v_q <= s2_v_q;
        if (s2_v_q) begin
          quo_mag_q     <= quo_mag_d;
          quo_neg_q     <= s2_neg_q;
          div_by_zero_q <= s2_dz_q;
        end
      end
    end
  end

  assign in_ready    = s1_en;
  assign out_valid   = s3_v_q;
  assign quo_mag     = quo_mag_q;
  assign quo_neg     = quo_neg_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_mitch_log_div_pipe.sv
// Self-checking bench for mitch_log_div_pipe: directed vectors, stall/drain, async reset, random stream.
module tb_mitch_log_div_pipe;

  localparam int FW = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quo_mag;
  logic        quo_neg;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;
  int drained = 0;
  logic [33:0] sb[$];

  mitch_log_div_pipe #(.FRAC_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quo_mag(quo_mag), .quo_neg(quo_neg), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Mitchell log value (integer units of 2^-FW) from the arithmetic definition
  function automatic int logv(input int x);
    int k;
    k = 0;
    while ((1 << (k + 1)) <= x) k++;
    return k * (1 << FW) + ((x - (1 << k)) * (1 << FW)) / (1 << k);
  endfunction

  function automatic logic [33:0] model(input logic [15:0] a, input logic [15:0] b);
    int ma, mb, l, ip, fp;
    longint v;
    ma = a[15] ? 65536 - int'(a) : int'(a);
    mb = b[15] ? 65536 - int'(b) : int'(b);
    if (mb == 0) return {32'hFFFF_FFFF, a[15], 1'b1};
    if (ma == 0) return {32'd0, 1'b0, 1'b0};
    l = logv(ma) - logv(mb);
`ifdef MITCH_DIV_BIAS_EN
    l = l + 2;
`endif
    ip = (l >= 0) ? l / (1 << FW) : -((-l + (1 << FW) - 1) / (1 << FW));
    fp = l - ip * (1 << FW);
    v  = (longint'((1 << FW) + fp) << (ip + 16)) >> FW;
    return {32'(v), a[15] ^ b[15], 1'b0};
  endfunction

  // Scoreboard: push on accept, pop and compare on drain
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back(model(dividend, divisor));
      if (out_valid && out_ready) begin
        drained++;
        if (sb.size() == 0) chk("unexpected_out", 64'({quo_mag, quo_neg, div_by_zero}), 64'h0);
        else chk("stream_result", 64'({quo_mag, quo_neg, div_by_zero}), 64'(sb.pop_front()));
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input bit rnd);
    bit acc;
    acc = 1'b0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 64'(acc), 64'h1);
  endtask

  task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] em, input logic en, input logic ez);
    int lat;
    lat = 0;
    out_ready = 1'b1;
    send(a, b, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      lat = i;
      if (out_valid) break;
    end
    chk("latency", 64'(lat), 64'd3);
    chk("dir_valid", 64'(out_valid), 64'h1);
    chk("dir_mag", 64'(quo_mag), 64'(em));
    chk("dir_neg_dz", 64'({quo_neg, div_by_zero}), 64'({en, ez}));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    logic [15:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 64'({out_valid, quo_mag, quo_neg, div_by_zero}), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    @(posedge clk);
    #1;

`ifdef MITCH_DIV_BIAS_EN
    run_one(16'd100, 16'd10, 32'h000B_0000, 1'b0, 1'b0);
`else
    run_one(16'd100, 16'd10, 32'h000A_8000, 1'b0, 1'b0);
    run_one(16'hFFF9, 16'd2, 32'h0003_8000, 1'b1, 1'b0);
    run_one(16'h8000, 16'd1, 32'h8000_0000, 1'b1, 1'b0);
    run_one(16'd1, 16'd32767, 32'h0000_0002, 1'b0, 1'b0);
`endif
    run_one(16'd0, 16'd7, 32'h0, 1'b0, 1'b0);
    run_one(16'd5, 16'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_one(16'hFFFB, 16'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);

    // Stall: three accepts fill the pipe, then hold for 5 cycles
    out_ready = 1'b0;
    d0 = drained;
    send(16'd1000, 16'd3, 1'b0);
    send(16'hFC18, 16'd7, 1'b0);
    send(16'd12345, 16'hFF00, 1'b0);
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 64'h0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'h1);
      chk("stall_hold", 64'({quo_mag, quo_neg, div_by_zero}), (sb.size() > 0) ? 64'(sb[0]) : 64'h0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'd7, 16'd9, 1'b0);
    send(16'd32767, 16'd1, 1'b0);
    send(16'd300, 16'hFFFD, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_rate", 64'(out_valid), 64'h1);
      @(posedge clk);
      #1;
    end
    chk("drain_count", 64'(drained - d0), 64'd6);
    chk("drain_empty", 64'(sb.size()), 64'd0);

    // Async reset with three results in flight
    out_ready = 1'b0;
    send(16'd11, 16'd2, 1'b0);
    send(16'd22, 16'd3, 1'b0);
    send(16'd33, 16'd4, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'h0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(out_valid), 64'h0);
    end
    @(posedge clk);
    #1;

    // Random stream with random backpressure, occasional boundary operands
    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 9))
        0: ra = 16'h0;
        1: rb = 16'h0;
        2: ra = 16'h8000;
        3: rb = 16'h8000;
        4: rb = 16'($urandom_range(1, 8));
        default: ;
      endcase
      send(ra, rb, 1'b1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("final_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
